gray_run_ctrl: RTL and testbench

//   Run controller for the gray-code counter datapath. Accepts a run command carrying a step count.

---
 rtl/gray_ctrl_pkg.sv | 19 +
 rtl/gray_core.sv | 31 +++
 rtl/gray_run_ctrl.sv | 101 ++++++++++
 tb/tb_gray_run_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ctrl_pkg.sv
// Shared types and helpers for the gray-code run controller and its counter core.
package gray_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WRAP_W_DEF = 4;
  localparam int WRAP_MAX   = (1 << WRAP_W_DEF) - 1;

  // Widest-case conversion; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_core.sv
// Binary counter with registered gray-code output; advances only while En is high.
module gray_core
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] GrayOut,
  output logic             WrapPulse
);

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_inc;

  assign b_inc     = b + WIDTH'(1);
  assign WrapPulse = En & (b == '1);

  // Gray is registered from the incremented value so it changes on the same edge as b.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      b       <= '0;
      GrayOut <= '0;
    end else if (En) begin
      b       <= b_inc;
      GrayOut <= WIDTH'(bin2gray(32'(b_inc)));
    end
  end

endmodule

// File: rtl/gray_run_ctrl.sv
// Run controller: sequences the gray core's enable for a requested number of advances,
// with pause/abort, saturating wrap count, sticky overflow and a one-cycle Done pulse.
module gray_run_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int CNT_W  = 8,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Steps,
  input  logic              Pause,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  GrayOut,
  output logic [WRAP_W-1:0] WrapCnt,
  output logic              Overflow,
  output state_t            dbg_state
);

  // Handshake: Start is a single-cycle request accepted only in IDLE; no ready is returned,
  // Busy is the acknowledgement (high from the edge after acceptance until the run ends).

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining;
  logic             en, load, clr;
  logic             wrap_pulse;

  gray_core #(.WIDTH(WIDTH)) u_core (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (en),
    .GrayOut  (GrayOut),
    .WrapPulse(wrap_pulse)
  );

  always_comb begin
    state_d = state_q;
    en      = 1'b0;
    load    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          clr = 1'b1;
          if (Steps != '0) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // Abort outranks Pause; neither advances the counter in this cycle.
        if (Abort) begin
          state_d = IDLE;
        end else if (Pause) begin
          state_d = HOLD;
        end else begin
          en = 1'b1;
          if (remaining == CNT_W'(1)) state_d = DONE;
        end
      end
      HOLD: begin
        if (Abort)       state_d = IDLE;
        else if (!Pause) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      remaining <= '0;
      WrapCnt   <= '0;
      Overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load)    remaining <= Steps;
      else if (en) remaining <= remaining - CNT_W'(1);
      if (clr) begin
        WrapCnt  <= '0;
        Overflow <= 1'b0;
      end else if (wrap_pulse) begin
        if (WrapCnt != '1) WrapCnt <= WrapCnt + WRAP_W'(1);
        Overflow <= 1'b1;
      end
    end
  end

  assign Busy      = (state_q == RUN) || (state_q == HOLD);
  assign Done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Self-checking bench for gray_run_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a run-level behavioural model.
module tb_gray_run_ctrl;
  import gray_ctrl_pkg::*;

  localparam int WIDTH  = 3;
  localparam int CNT_W  = 8;
  localparam int WRAP_W = 4;
  localparam int MODV   = 8;
  localparam int SATV   = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  steps = '0;
  logic              pause = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, overflow;
  logic [WIDTH-1:0]  gray;
  logic [WRAP_W-1:0] wrap_cnt;
  state_t            dbg_state;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  logic [9:0] exp_q[$];

  gray_run_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WRAP_W(WRAP_W)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Steps(steps), .Pause(pause), .Abort(abort),
    .Busy(busy), .Done(done), .GrayOut(gray), .WrapCnt(wrap_cnt), .Overflow(overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Run-level view: an active run owes m_rem advances; a paused run loses the pause-entry
  // and resume cycles; total wraps are counted unbounded and clipped only on output.
  int m_count = 0, m_wraps = 0, m_rem = 0;
  bit m_active = 0, m_held = 0, m_done = 0;

  function automatic logic [9:0] model_out();
    int g;
    int w;
    g = m_count ^ (m_count >> 1);
    w = (m_wraps > SATV) ? SATV : m_wraps;
    return {m_active, m_done, 3'(g), 4'(w), (m_wraps > 0)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_count = 0; m_wraps = 0; m_rem = 0;
      m_active = 0; m_held = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_wraps = 0;
        if (steps == 0) m_done = 1;
        else begin
          m_active = 1; m_held = 0; m_rem = int'(steps);
        end
      end
    end else if (abort) begin
      m_active = 0;
    end else if (m_held) begin
      if (!pause) m_held = 0;
    end else if (pause) begin
      m_held = 1;
    end else begin
      if (m_count == MODV - 1) m_wraps++;
      m_count = (m_count + 1) % MODV;
      m_rem--;
      if (m_rem == 0) begin
        m_active = 0; m_done = 1;
      end
    end
    exp_q.push_back(model_out());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_outputs", int'({busy, done, gray, wrap_cnt, overflow}), int'(e));
    end
    if (done) done_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; steps = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Returns at the negedge just after the edge that accepted Start.
  task automatic issue(input int n);
    start = 1'b1;
    steps = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] exp1[3];
    logic [2:0] g[11];
    int d0;
    exp1 = '{3'b001, 3'b011, 3'b010};

    // 1. reset state, then Steps=3
    do_reset();
    check("reset_busy", int'(busy), 0);
    check("reset_gray", int'(gray), 0);
    check("reset_wrap", int'(wrap_cnt), 0);
    check("reset_ovf", int'(overflow), 0);
    check("reset_done", int'(done), 0);
    d0 = done_seen;
    issue(3);
    check("t1_busy_after_start", int'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_gray_seq", int'(gray), int'(exp1[i]));
      if (i < 2) check("t1_busy", int'(busy), 1);
    end
    check("t1_done", int'(done), 1);
    check("t1_busy_in_done", int'(busy), 0);
    check("t1_wrap", int'(wrap_cnt), 0);
    check("t1_ovf", int'(overflow), 0);
    tick();
    check("t1_done_one_cycle", int'(done), 0);
    check("t1_done_count", done_seen - d0, 1);

    // 2. Steps=10, wrap on 8th advance
    do_reset();
    d0 = done_seen;
    issue(10);
    g[0] = gray;
    for (int i = 1; i <= 10; i++) begin
      tick();
      g[i] = gray;
    end
    check("t2_gray_7", int'(g[7]), 3'b100);
    check("t2_gray_8_wrapped", int'(g[8]), 3'b000);
    check("t2_done", int'(done), 1);
    tick(); tick();
    check("t2_gray_final", int'(gray), 3'b011);
    check("t2_wrap", int'(wrap_cnt), 1);
    check("t2_ovf", int'(overflow), 1);
    check("t2_done_count", done_seen - d0, 1);

    // 3. Steps=5, pause two cycles after the 2nd advance
    do_reset();
    d0 = done_seen;
    issue(5);
    tick(); tick();
    check("t3_gray_2nd", int'(gray), 3'b011);
    pause = 1'b1;
    tick();
    check("t3_hold_a", int'(gray), 3'b011);
    tick();
    check("t3_hold_b", int'(gray), 3'b011);
    pause = 1'b0;
    tick();
    check("t3_resume_no_adv", int'(gray), 3'b011);
    check("t3_done_not_early", int'(done), 0);
    tick(); tick();
    check("t3_done_not_yet", int'(done), 0);
    tick();
    check("t3_done_late", int'(done), 1);
    check("t3_gray_final", int'(gray), 3'b111);
    tick();
    check("t3_done_count", done_seen - d0, 1);

    // 4. Steps=5, abort after the 2nd advance
    do_reset();
    d0 = done_seen;
    issue(5);
    tick(); tick();
    abort = 1'b1;
    tick();
    check("t4_busy", int'(busy), 0);
    check("t4_gray", int'(gray), 3'b011);
    abort = 1'b0;
    repeat (10) tick();
    check("t4_gray_frozen", int'(gray), 3'b011);
    check("t4_no_done", done_seen - d0, 0);

    // 5. Start while busy ignored; Steps=0 gives a bare Done
    do_reset();
    d0 = done_seen;
    issue(6);
    tick();
    start = 1'b1; steps = 8'd1;
    tick(); tick();
    start = 1'b0;
    wait_done(20);
    check("t5_gray_6", int'(gray), 3'b101);
    tick();
    issue(0);
    check("t5_zero_done", int'(done), 1);
    check("t5_zero_busy", int'(busy), 0);
    check("t5_zero_gray", int'(gray), 3'b101);
    tick();
    check("t5_zero_done_off", int'(done), 0);
    check("t5_done_count", done_seen - d0, 2);

    // 6. Steps=200 saturates wraps; then reset mid-run
    do_reset();
    issue(200);
    wait_done(300);
    check("t6_wrap_sat", int'(wrap_cnt), 15);
    check("t6_ovf", int'(overflow), 1);
    check("t6_gray", int'(gray), 3'b000);
    tick();
    d0 = done_seen;
    issue(200);
    repeat (40) tick();
    reset = 1'b1;
    tick();
    check("t6_rst_outputs", int'({busy, done, gray, wrap_cnt, overflow}), 0);
    reset = 1'b0;
    repeat (3) tick();
    check("t6_rst_no_done", done_seen - d0, 0);

    // Randomized traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0)       steps = '0;
      else if ($urandom_range(0, 30) == 0) steps = CNT_W'($urandom_range(100, 255));
      else                                 steps = CNT_W'($urandom_range(1, 24));
      pause = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 60) == 0);
      reset = ($urandom_range(0, 400) == 0);
      tick();
    end

    reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
